// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
// The FSM state encoding is fixed so that the debug state output is stable.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int wi_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int si_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Tag is whatever remains above byte offset, word index and set index.
  function automatic int tag_bits(input int addr_w, input int sets, input int line_words);
    return addr_w - 2 - $clog2(line_words) - $clog2(sets);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the cache: asynchronous read, per-word refill write,
// line-valid write on the last beat and a single-cycle clear of all valid bits.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [si_bits(SETS)-1:0]      rd_set,
  input  logic [wi_bits(LINE_WORDS)-1:0] rd_word,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [31:0]                   rd_data,
  input  logic                          wr_en,
  input  logic [si_bits(SETS)-1:0]      wr_set,
  input  logic [wi_bits(LINE_WORDS)-1:0] wr_word,
  input  logic [31:0]                   wr_data,
  input  logic                          fill_en,
  input  logic [TAG_W-1:0]              fill_tag,
  input  logic                          flush_en
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][LINE_WORDS];

  assign rd_valid = valid_q[rd_set];
  assign rd_tag   = tag_q[rd_set];
  assign rd_data  = data_q[rd_set][rd_word];

  // Only the valid bits are reset; stale tag/data are harmless behind valid=0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush_en) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[wr_set] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_set][wr_word] <= wr_data;
    end
    if (fill_en) begin
      tag_q[wr_set] <= fill_tag;
    end
  end

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: combinational hit path, stalling
// multi-beat line refill from a word-wide memory, and fence.i style flush.
module icache_direct_mapped
  import icache_pkg::*;
#(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic [31:0]       instr_o,
  output logic              hit_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       miss_count_o,
  output logic [1:0]        dbg_state
);

  localparam int WI = wi_bits(LINE_WORDS);
  localparam int SI = si_bits(SETS);
  localparam int TW = tag_bits(ADDR_W, SETS, LINE_WORDS);

  state_t            state;
  logic [WI-1:0]     cnt;
  logic [ADDR_W-1:0] base;
  logic              flush_pend;

  logic [SI-1:0] rd_set;
  logic [WI-1:0] rd_word;
  logic [TW-1:0] pc_tag;
  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  logic [31:0]   rd_data;
  logic          beat_fire;
  logic          last_beat;
  logic          unused_pc_bits;

  assign rd_set         = pc_i[2+WI +: SI];
  assign rd_word        = pc_i[2 +: WI];
  assign pc_tag         = pc_i[ADDR_W-1 -: TW];
  assign unused_pc_bits = &{1'b0, pc_i[1:0]};

  assign beat_fire = (state == ST_REFILL) && mem_rvalid_i;
  assign last_beat = beat_fire && (cnt == WI'(LINE_WORDS - 1));

  icache_line_store #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TW)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_set   (rd_set),
    .rd_word  (rd_word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (beat_fire),
    .wr_set   (base[2+WI +: SI]),
    .wr_word  (cnt),
    .wr_data  (mem_rdata_i),
    .fill_en  (last_beat),
    .fill_tag (base[ADDR_W-1 -: TW]),
    .flush_en (state == ST_FLUSH)
  );

  assign hit_o      = (state == ST_IDLE) && req_i && rd_valid && (rd_tag == pc_tag);
  assign instr_o    = hit_o ? rd_data : NOP_INSTR;
  assign stall_o    = (state != ST_IDLE) || flush_i || (req_i && !hit_o);
  assign mem_req_o  = (state == ST_REFILL);
  assign mem_addr_o = mem_req_o ? (base + ADDR_W'({cnt, 2'b00})) : '0;
  assign dbg_state  = state;

  // A flush seen during refill is deferred until the line has landed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      base         <= '0;
      flush_pend   <= 1'b0;
      miss_count_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush_i) begin
            state <= ST_FLUSH;
          end else if (req_i && !hit_o) begin
            base  <= {pc_i[ADDR_W-1:WI+2], {(WI+2){1'b0}}};
            cnt   <= '0;
            state <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (flush_i) begin
            flush_pend <= 1'b1;
          end
          if (beat_fire) begin
            cnt <= cnt + WI'(1);
          end
          if (last_beat) begin
            miss_count_o <= miss_count_o + 32'd1;
            state        <= (flush_pend || flush_i) ? ST_FLUSH : ST_IDLE;
          end
        end
        ST_FLUSH: begin
          flush_pend <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped: a memory model serves refills and
// expected instructions are queued at fetch issue and compared when a hit returns.
module tb_icache_direct_mapped;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic [31:0] instr;
  logic        hit;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] miss_count;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  logic [31:0] exp_base = '0;
  int beat = 0;
  int gap = 0;
  int gap_left = 0;

  icache_direct_mapped dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .pc_i         (pc),
    .flush_i      (flush),
    .instr_o      (instr),
    .hit_o        (hit),
    .stall_o      (stall),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .miss_count_o (miss_count),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic reset_dut();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + ((a - 32'h100) >> 2);
  endfunction

  // Backing memory: checks the beat address and answers after `gap` idle cycles.
  task automatic mem_model();
    if (mem_req) begin
      check("mem_addr", mem_addr, exp_base + 32'(4 * beat));
      if (gap_left == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(exp_base + 32'(4 * beat));
        beat       = (beat == 3) ? 0 : beat + 1;
        gap_left   = gap;
      end else begin
        gap_left--;
      end
    end
  endtask

  // driver: one fetch until hit, optionally pulsing flush on cycle flush_at
  task automatic fetch(input logic [31:0] a, input int exp_stalls, input int flush_at);
    int  stalls;
    bit  done;
    req      = 1'b1;
    pc       = a;
    exp_base = a & 32'hFFFF_FFF0;
    beat     = 0;
    gap_left = 0;
    exp_q.push_back(mem_word(a & 32'hFFFF_FFFC));
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      flush = (c == flush_at);
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (hit) begin
        check("instr", instr, exp_q.pop_front());
        check("stall_on_hit", {31'd0, stall}, 32'd0);
        check("mem_req_on_hit", {31'd0, mem_req}, 32'd0);
        done = 1'b1;
      end else begin
        stalls++;
        mem_model();
      end
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    req   = 1'b0;
    if (!done) begin
      check("fetch_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
  endtask

  task automatic step();
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_dut();
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    @(posedge clk);
    #1;

    // cold miss then hits within the line
    fetch(32'h100, 5, -1);
    check("miss_count_cold", miss_count, 32'd1);
    fetch(32'h108, 0, -1);
    fetch(32'h10C, 0, -1);

    // conflict misses on set 0
    fetch(32'h500, 5, -1);
    fetch(32'h100, 5, -1);
    check("miss_count_conflict", miss_count, 32'd3);

    // slow memory with 3-cycle gaps between beats
    gap = 3;
    fetch(32'h204, 14, -1);
    gap = 0;
    check("miss_count_slow", miss_count, 32'd4);
    fetch(32'h200, 0, -1);
    fetch(32'h20C, 0, -1);

    // random re-hits within the cached line
    for (int i = 0; i < 4; i++) begin
      fetch(32'h200 + 32'(4 * $urandom_range(0, 3)), 0, -1);
    end

    // flush in IDLE
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle_stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_state", {30'd0, dbg_state}, 32'd2);
    check("flush_cycle_stall", {31'd0, stall}, 32'd1);
    check("flush_cycle_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    fetch(32'h200, 5, -1);
    check("miss_count_after_flush", miss_count, 32'd5);

    // flush during refill: refill completes, FLUSH, then a re-miss
    fetch(32'h308, 11, 2);
    check("miss_count_flush_refill", miss_count, 32'd7);

    // reset after two beats of a refill
    fetch(32'h700, 5, -1);
    req      = 1'b1;
    pc       = 32'h100;
    exp_base = 32'h100;
    beat     = 0;
    gap_left = 0;
    step();
    step();
    step();
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_miss_count", miss_count, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_instr", instr, 32'h0000_0013);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rvalid_state", {30'd0, dbg_state}, 32'd0);
    check("late_rvalid_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    fetch(32'h100, 5, -1);
    check("miss_count_post_rst", miss_count, 32'd1);
    fetch(32'h104, 0, -1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
